// File: rtl/axis_drain_pkg.sv
// Shared types and constants for the AXI-Stream FIFO drain block.
// Optional first-beat tuser marker: AXIS_DRAIN_TUSER_SOF_EN.
package axis_drain_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LEN_W = 16;

  localparam logic [1:0] BUF_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry head/skid output buffer for the drain stream.
// Pushes come from FIFO pops; pops are stream handshakes.
module axis_skid_buf
  import axis_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             tready,
  output logic [1:0]       occ,
  output logic             tvalid,
  output logic [WIDTH-1:0] tdata
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;
  logic [1:0]       occ_q;
  logic             acc;

  assign acc    = tvalid & tready;
  assign tvalid = (occ_q != 2'd0);
  assign tdata  = head;
  assign occ    = occ_q;

  // push is never raised at full occupancy by the owner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      skid  <= '0;
      occ_q <= 2'd0;
    end else begin
      unique case ({push, acc})
        2'b10: begin
          if (occ_q == 2'd0) head <= din;
          else               skid <= din;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head  <= skid;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head <= din;
          end else begin
            head <= skid;
            skid <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_fifo_drain.sv
// FIFO-to-AXI-Stream drain with frame length, tlast and frame_done.
// Optional first-beat tuser marker: AXIS_DRAIN_TUSER_SOF_EN.
module axis_fifo_drain
  import axis_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_r_ready,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_frame_len,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
`ifdef AXIS_DRAIN_TUSER_SOF_EN
  output logic             m_axis_tuser,
`endif
  output logic             frame_done
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state;
  state_t           state_n;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] pop_rem;
  logic [LEN_W-1:0] beat_cnt;
  logic [1:0]       occ;
  logic             start_ok;
  logic             pop;
  logic             acc;
  logic             last_acc;

  assign start_ok = (state == IDLE) & cfg_start
                  & (cfg_frame_len != '0);

  // pop strobe sees only registered state, never tready
  assign fifo_r_ready = (state == RUN) & ~fifo_empty
                      & (pop_rem != '0)
                      & (occ < BUF_DEPTH);
  assign pop = fifo_r_ready;

  assign acc      = m_axis_tvalid & m_axis_tready;
  assign last_acc = acc & m_axis_tlast;

  assign m_axis_tlast = m_axis_tvalid
                      & (beat_cnt == len_q - ONE);
  assign busy = (state != IDLE);

`ifdef AXIS_DRAIN_TUSER_SOF_EN
  assign m_axis_tuser = m_axis_tvalid & (beat_cnt == '0);
`endif

  axis_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (pop),
    .din    (fifo_data),
    .tready (m_axis_tready),
    .occ    (occ),
    .tvalid (m_axis_tvalid),
    .tdata  (m_axis_tdata)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start_ok) state_n = RUN;
      RUN:   if (pop && pop_rem == ONE) state_n = DRAIN;
      DRAIN: if (last_acc) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      pop_rem    <= '0;
      beat_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= last_acc;
      if (start_ok) begin
        len_q   <= cfg_frame_len;
        pop_rem <= cfg_frame_len;
      end else if (pop) begin
        pop_rem <= pop_rem - ONE;
      end
      if (start_ok || last_acc) beat_cnt <= '0;
      else if (acc)             beat_cnt <= beat_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_axis_fifo_drain.sv
// Directed bench for axis_fifo_drain with a queue-backed FIFO model.
// Build with AXIS_DRAIN_TUSER_SOF_EN to also check the tuser marker.
module tb_axis_fifo_drain;

  localparam int W  = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_data = '0;
  logic          fifo_r_ready;
  logic          cfg_start = 1'b0;
  logic [LW-1:0] cfg_frame_len = '0;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          busy;
  logic          frame_done;
`ifdef AXIS_DRAIN_TUSER_SOF_EN
  logic          m_axis_tuser;
`endif

  axis_fifo_drain #(
    .WIDTH (W),
    .LEN_W (LW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_r_ready  (fifo_r_ready),
    .cfg_start     (cfg_start),
    .cfg_frame_len (cfg_frame_len),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
`ifdef AXIS_DRAIN_TUSER_SOF_EN
    .m_axis_tuser  (m_axis_tuser),
`endif
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // FIFO model: pops decided mid-cycle, applied just after the edge
  logic [W-1:0] q[$];
  bit           pop_q = 1'b0;
  int           cyc = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (pop_q) void'(q.pop_front());
    fifo_empty = (q.size() == 0);
    fifo_data  = fifo_empty ? '0 : q[0];
  end

  int           occ_m = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] b_data[$];
  bit           b_last[$];
  bit           b_user[$];
  int           b_cyc[$];
  int           done_cnt = 0;
  int           done_cyc = -1;
  bit           done_busy = 1'b0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;
  int           gap_cnt = 0;

  always @(negedge clk) begin
    bit acc;
    pop_q = fifo_r_ready && !fifo_empty;
    acc   = m_axis_tvalid && m_axis_tready;
    if (rst_n) begin
      check("tvalid_occ", m_axis_tvalid, occ_m != 0);
      if (occ_m == 2) check("no_pop_full", fifo_r_ready, 0);
      if (stall_prev) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_data", m_axis_tdata, stall_data);
      end
      if (pop_q) exp_q.push_back(fifo_data);
      if (acc) begin
        if (exp_q.size() == 0) begin
          check("sb_extra", m_axis_tdata, 64'hdead);
        end else begin
          check("sb_order", m_axis_tdata, exp_q[0]);
          void'(exp_q.pop_front());
        end
        b_data.push_back(m_axis_tdata);
        b_last.push_back(m_axis_tlast);
`ifdef AXIS_DRAIN_TUSER_SOF_EN
        b_user.push_back(m_axis_tuser);
`else
        b_user.push_back(1'b0);
`endif
        b_cyc.push_back(cyc);
      end
      if (busy && !m_axis_tvalid) gap_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
      occ_m = occ_m + int'(pop_q) - int'(acc);
    end else begin
      occ_m = 0;
      exp_q.delete();
      stall_prev = 1'b0;
    end
  end

  bit tr_toggle = 1'b0;
  bit tr_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (tr_toggle) m_axis_tready = tr_pat[cyc % 4];
    end
  endtask

  task automatic fill(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) q.push_back(base + W'(i));
  endtask

  task automatic clear_beats();
    b_data.delete();
    b_last.delete();
    b_user.delete();
    b_cyc.delete();
  endtask

  task automatic start(input int len);
    cfg_frame_len = LW'(len);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done"}, done_cnt - d0, 1);
  endtask

  task automatic wait_beats(input string tag, input int nb);
    int n;
    n = 0;
    while (b_data.size() < nb && n < 50) begin
      step();
      n++;
    end
    check({tag, "_beats"}, b_data.size(), nb);
  endtask

  task automatic check_frame(input string tag,
                             input logic [W-1:0] base,
                             input int len);
    check({tag, "_n"}, b_data.size(), len);
    for (int i = 0; i < len && i < b_data.size(); i++) begin
      check($sformatf("%s_d%0d", tag, i), b_data[i], base + W'(i));
      check($sformatf("%s_l%0d", tag, i), b_last[i], i == len - 1);
`ifdef AXIS_DRAIN_TUSER_SOF_EN
      check($sformatf("%s_u%0d", tag, i), b_user[i], i == 0);
`endif
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tdata"}, m_axis_tdata, 0);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_rready"}, fifo_r_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
  endtask

  initial begin
    int d0;
    int g0;

    step(3);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    step();

    // back-to-back frame of four
    fill(32'hA0, 4);
    clear_beats();
    d0 = done_cnt;
    start(4);
    wait_done("f4", 40);
    check_frame("f4", 32'hA0, 4);
    for (int i = 1; i < 4 && i < b_cyc.size(); i++)
      check($sformatf("f4_c%0d", i), b_cyc[i] - b_cyc[0], i);
    if (b_cyc.size() == 4) check("f4_donecyc", done_cyc, b_cyc[3] + 1);
    check("f4_donebusy", done_busy, 0);
    step();
    check("f4_pulse", frame_done, 0);
    check("f4_once", done_cnt - d0, 1);

    // frame shorter than FIFO content
    q.delete();
    fill(32'hB0, 5);
    clear_beats();
    start(3);
    wait_done("f3", 40);
    step(3);
    check_frame("f3", 32'hB0, 3);
    check("f3_left", q.size(), 2);
    if (q.size() > 0) check("f3_head", q[0], 32'hB3);
    check("f3_idle", busy, 0);

    // zero-length start and start during a frame
    q.delete();
    fill(32'hD0, 5);
    step();
    d0 = done_cnt;
    clear_beats();
    start(0);
    step(5);
    check("z_busy", busy, 0);
    check("z_q", q.size(), 5);
    check("z_done", done_cnt - d0, 0);
    check("z_beats", b_data.size(), 0);
    start(3);
    start(5);
    wait_done("ign", 40);
    step(3);
    check_frame("ign", 32'hD0, 3);
    check("ign_left", q.size(), 2);

    // tready pattern 1,0,0,1 with backpressure
    q.delete();
    fill(32'hC0, 6);
    clear_beats();
    step();
    tr_toggle = 1'b1;
    start(6);
    wait_done("bp", 200);
    tr_toggle = 1'b0;
    m_axis_tready = 1'b1;
    check_frame("bp", 32'hC0, 6);

    // FIFO underflow mid-frame
    q.delete();
    fill(32'hE0, 2);
    clear_beats();
    step();
    start(5);
    wait_beats("uf", 2);
    g0 = gap_cnt;
    step(10);
    check("uf_gap", gap_cnt - g0 >= 5, 1);
    check("uf_busy", busy, 1);
    fill(32'hE2, 3);
    wait_done("uf", 40);
    check_frame("uf", 32'hE0, 5);

    // reset mid-frame, then a clean short frame
    q.delete();
    fill(32'hF0, 8);
    clear_beats();
    step();
    start(8);
    wait_beats("mr", 2);
    rst_n = 1'b0;
    step();
    check_idle_outputs("mr");
    rst_n = 1'b1;
    q.delete();
    fill(32'h60, 2);
    clear_beats();
    step(2);
    start(2);
    wait_done("post", 40);
    check_frame("post", 32'h60, 2);
    step(2);
    check("post_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_fifo_drain.md
Name: axis_fifo_drain

Overview:
- Downstream consumer of the stream FIFO.
- Pops words from the FIFO read side and presents them as an AXI-Stream master with a 2-entry output buffer, so the FIFO read strobe never depends combinationally on m_axis_tready.
- Frames the stream: tlast on the last beat of a software-programmed frame length, plus a frame_done pulse back to FIR control.

Parameters:
- WIDTH, 32, data width; equals the FIFO WIDTH.
- LEN_W, 16, width of the frame-length and beat counters.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- fifo_empty  input  1  FIFO empty status (driven from the FIFO pre_empty)
- fifo_data  input  WIDTH  FIFO data_out; combinational head word, valid when fifo_empty=0
- fifo_r_ready  output  1  pop strobe into the FIFO r_ready; a pop occurs on a clk edge where fifo_r_ready=1 and fifo_empty=0
- cfg_start  input  1  single-cycle frame start request
- cfg_frame_len  input  LEN_W  beats per frame; sampled on an accepted start
- m_axis_tdata  output  WIDTH  stream data
- m_axis_tvalid  output  1  stream valid
- m_axis_tready  input  1  stream ready
- m_axis_tlast  output  1  last beat of frame
- busy  output  1  high while state != IDLE
- frame_done  output  1  one-cycle pulse when the last beat is accepted

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; both buffer entries invalid.
  - All counters 0.
  - All outputs 0: tdata=0, tvalid=0, tlast=0, fifo_r_ready=0, busy=0, frame_done=0.
  - Reset mid-frame discards buffered words; words already popped are lost.
- State machine, IDLE / RUN / DRAIN:
  - IDLE -> RUN: cfg_start=1 and cfg_frame_len!=0. Latch len; pop_rem=len; beat_cnt=0.
  - cfg_start with len=0 is ignored: stay IDLE, no frame_done.
  - cfg_start in RUN or DRAIN is ignored.
  - RUN -> DRAIN: on the edge where the final pop occurs (pop_rem 1->0).
  - DRAIN -> IDLE: on the edge where the final beat is accepted (tvalid & tready & tlast). frame_done=1 in the following cycle only.
- Pop rule: fifo_r_ready = (state==RUN) & !fifo_empty & (pop_rem!=0) & (occ<2).
  - Depends only on registered state and fifo_empty, never on m_axis_tready.
  - On a pop, fifo_data is captured into the buffer tail the same edge.
- Output buffer: 2 entries, head/skid, with occupancy occ in 0..2.
  - tvalid = occ!=0; tdata = head entry.
  - Acceptance is tvalid & tready. On acceptance the skid entry shifts to head.
  - Simultaneous pop and accept: occ is unchanged.
  - Order is strictly preserved.
  - tdata/tvalid hold stable while tvalid=1 and tready=0.
- Throughput: 1 beat/cycle sustained when the FIFO is non-empty and tready=1. First beat appears 1 cycle after the first pop edge.
- tlast = tvalid & (beat_cnt == len-1).
  - beat_cnt increments per accepted beat and clears on frame end.
  - len = 2^LEN_W-1 maximum; no wrap inside a frame.
- FIFO underflow (empty mid-frame): the block stalls with no pop. tvalid drops once the buffer drains; no timeout.
- Never pops beyond len words: words of the next frame stay in the FIFO.

Optional Feature:
- Macro AXIS_DRAIN_TUSER_SOF_EN.
- Defined:
  - Adds output port m_axis_tuser (1 bit) = tvalid & (beat_cnt==0), marking the first beat of each frame.
  - For len=1, tuser and tlast assert on the same beat.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package axis_drain_pkg:
  - state enum (IDLE, RUN, DRAIN)
  - default WIDTH/LEN_W localparams
  - buffer depth constant (2)
- Sub-module axis_skid_buf: the 2-entry buffer (push, data in, occ, tvalid/tready/tdata out). The FSM and counters stay in the top.

Test Plan:
- len=4, FIFO preloaded 0xA0..0xA3, tready=1 constantly -> beats A0,A1,A2,A3 on consecutive cycles; tlast only on A3; frame_done pulses 1 cycle after the A3 handshake; busy falls with it.
- len=3, FIFO holds 5 words -> exactly 3 pops; 2 words remain (FIFO drp=2); DRAIN->IDLE.
- len=6, tready toggles 1,0,0,1 repeating -> fifo_r_ready never high while occ=2; no data loss or duplication; tdata stable during stalls; tlast on the 6th beat.
- cfg_start with len=0 -> remains IDLE, no pop, no frame_done. Second cfg_start mid-RUN -> ignored; frame length unchanged.
- FIFO empties after 2 of 5 words, refilled 10 cycles later -> tvalid low during the gap; frame completes with 5 beats and tlast on the 5th.
- rst_n=0 for one cycle after beat 2 of len=8 -> next cycle all outputs 0 and state IDLE; a new start with len=2 runs cleanly. With AXIS_DRAIN_TUSER_SOF_EN, tuser is high on the first beat only.
